// File: rtl/switch_pkg.sv
// Shared constants and helpers for the switch debouncer.
package switch_pkg;

  localparam int unsigned STABLE_DEFAULT = 50000;
  localparam int unsigned STABLE_SIM     = 4;

  // Counter must hold 0..stable-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned stable);
    return (stable > 2) ? $clog2(stable) : 1;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: two-flop synchroniser, stability counter, debounced level and edge strobes.
module debounce_bit
  import switch_pkg::*;
#(
  parameter int unsigned STABLE = STABLE_DEFAULT,
  parameter logic        INIT   = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic o_o,
  output logic rise_o,
  output logic fall_o,
  output logic flip_o
);

  localparam int unsigned CntW = cnt_width(STABLE);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE - 1);

  logic            s1_q, s1_d;
  logic            s2_q, s2_d;
  logic            lvl_q, lvl_d;
  logic            rise_q, rise_d;
  logic            fall_q, fall_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    s1_d   = d_i;
    s2_d   = s1_q;
    lvl_d  = lvl_q;
    cnt_d  = '0;
    rise_d = 1'b0;
    fall_d = 1'b0;
    // Any agreement with the current level discards accumulated count.
    if (s2_q != lvl_q) begin
      if (cnt_q == CntMax) begin
        lvl_d  = s2_q;
        rise_d = s2_q;
        fall_d = ~s2_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q   <= INIT;
      s2_q   <= INIT;
      lvl_q  <= INIT;
      cnt_q  <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      lvl_q  <= lvl_d;
      cnt_q  <= cnt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign o_o    = lvl_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
  // Next-cycle strobe, lets the parent register CHANGED alongside rise/fall.
  assign flip_o = rise_d | fall_d;

endmodule

// File: rtl/switch_debouncer.sv
// Debounced switch bank: WIDTH independent filtered bits plus a registered any-change strobe.
module switch_debouncer
  import switch_pkg::*;
#(
  parameter int unsigned      WIDTH  = 3,
  parameter int unsigned      STABLE = STABLE_DEFAULT,
  parameter logic [WIDTH-1:0] INIT   = '0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] O,
  output logic [WIDTH-1:0] RISE,
  output logic [WIDTH-1:0] FALL,
  output logic             CHANGED
);

  logic [WIDTH-1:0] flip;
  logic             changed_q, changed_d;

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    debounce_bit #(
      .STABLE (STABLE),
      .INIT   (INIT[b])
    ) u_bit (
      .clk_i  (CLK),
      .rst_i  (RESET),
      .d_i    (I[b]),
      .o_o    (O[b]),
      .rise_o (RISE[b]),
      .fall_o (FALL[b]),
      .flip_o (flip[b])
    );
  end

  always_comb begin
    changed_d = |flip;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      changed_q <= 1'b0;
    end else begin
      changed_q <= changed_d;
    end
  end

  assign CHANGED = changed_q;

endmodule
